// File: rtl/ifetch_unit.sv
// Instruction-fetch sequencer: issues one imem request per PC, registers the
// fetched word for decode, advances or redirects the PC and flags fetch faults.
module ifetch_unit #(
  parameter int unsigned RESET_WAIT  = 1,
  parameter bit          CHECK_ALIGN = 1
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic        pc_wr,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        fetch_fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_e;

  localparam logic [3:0] WaitLast = 4'(RESET_WAIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        discard_q, discard_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic misalign;
  logic redir;
  logic resp;
  logic good;
  logic bus_err;

  assign misalign = CHECK_ALIGN && (pc_cur[1:0] != 2'b00);
  assign redir    = redirect_valid && (state_q != S_IDLE);
  assign resp     = (state_q == S_WAIT) && imem_rvalid;
  assign good     = resp && !discard_q && !imem_err && !redir;
  assign bus_err  = resp && !discard_q && imem_err && !redir;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      discard_q    <= 1'b0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      discard_q    <= discard_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;
    unique case (state_q)
      S_IDLE: begin
        if (cnt_q == WaitLast) state_d = S_HOLD;
        else cnt_d = cnt_q + 4'd1;
      end
      S_HOLD: begin
        if (!stall && (!if_valid_q || if_ready)) state_d = S_REQ;
      end
      S_REQ: begin
        if (misalign) state_d = S_FAULT;
        else if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          discard_d = 1'b0;
          state_d   = (!discard_q && imem_err) ? S_FAULT : S_HOLD;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    // redirect outranks everything else the current state wanted
    if (redir) begin
      unique case (state_q)
        S_WAIT: begin
          state_d   = imem_rvalid ? S_HOLD : S_WAIT;
          discard_d = !imem_rvalid;
        end
        S_REQ: begin
          state_d   = (imem_req && imem_gnt) ? S_WAIT : S_HOLD;
          discard_d = imem_req && imem_gnt;
        end
        default: state_d = S_HOLD;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    pc_wr     = 1'b0;
    pc_next   = '0;
    if (state_q == S_REQ && !misalign) begin
      imem_req  = 1'b1;
      imem_addr = pc_cur;
    end
    if (redir) begin
      pc_wr   = 1'b1;
      pc_next = redirect_pc;
    end else if (good) begin
      pc_wr   = 1'b1;
      pc_next = pc_cur + 32'd4;
    end
  end

  always_comb begin
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (if_valid_q && if_ready) if_valid_d = 1'b0;
    if (good) begin
      if_valid_d = 1'b1;
      if_instr_d = imem_rdata;
      if_pc_d    = pc_cur;
    end
    if ((state_q == S_REQ && misalign && !redir) || bus_err) begin
      fault_d      = 1'b1;
      fault_addr_d = pc_cur;
    end
    if (redir) begin
      if_valid_d   = 1'b0;
      fault_d      = 1'b0;
      fault_addr_d = '0;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign fetch_fault = fault_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed walk through the fetch scenarios, then
// randomized traffic checked cycle by cycle against a transaction-level model.
module tb_ifetch_unit;

  localparam int unsigned RW = 2;
  localparam bit          CA = 1;

  logic        CLK = 1'b0;
  logic        rst;
  logic [31:0] pc_reg;
  logic        pc_wr;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        fetch_fault;
  logic [31:0] fault_addr;

  ifetch_unit #(.RESET_WAIT(RW), .CHECK_ALIGN(CA)) dut (
    .CLK(CLK), .rst(rst), .pc_cur(pc_reg),
    .pc_wr(pc_wr), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready),
    .fetch_fault(fetch_fault), .fault_addr(fault_addr)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // memory behaviour knobs
  int unsigned gnt_pct, rv_pct, err_pct;
  bit          force_err, fixed_en;
  logic [31:0] fixed_data;

  // reference model: boot countdown plus request/outstanding/fault flags
  int unsigned m_boot;
  bit          m_issue, m_pend, m_drop, m_fault, m_v;
  logic [31:0] m_faddr, m_instr, m_ipc, pc_nxt;
  bit          e_req, e_pcwr;
  logic [31:0] e_addr, e_pcnext;

  logic        seen_req, seen_pcwr;
  logic [31:0] seen_addr, seen_pcnext;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot  = RW;
    m_issue = 0; m_pend = 0; m_drop = 0; m_fault = 0; m_v = 0;
    m_faddr = '0; m_instr = '0; m_ipc = '0;
    pc_nxt  = 32'h0040_0000;
  endtask

  task automatic model_comb();
    bit mis, rok, good;
    mis      = CA && (pc_reg[1:0] != 2'b00);
    e_req    = m_issue && !mis;
    e_addr   = e_req ? pc_reg : 32'h0;
    rok      = redirect_valid && (m_boot == 0);
    good     = m_pend && imem_rvalid && !m_drop && !imem_err;
    e_pcwr   = rok || good;
    e_pcnext = rok ? redirect_pc : (good ? pc_reg + 32'd4 : 32'h0);
  endtask

  task automatic model_seq();
    bit mis, can_go;
    if (rst) begin
      model_reset();
      return;
    end
    mis    = CA && (pc_reg[1:0] != 2'b00);
    can_go = !stall && (!m_v || if_ready);
    pc_nxt = e_pcwr ? e_pcnext : pc_reg;
    if (redirect_valid && m_boot == 0) begin
      m_v = 0; m_fault = 0; m_faddr = '0;
      if (m_pend) begin
        if (imem_rvalid) begin m_pend = 0; m_drop = 0; end
        else m_drop = 1;
      end else if (m_issue) begin
        m_issue = 0;
        m_pend  = imem_gnt;
        m_drop  = imem_gnt;
      end
    end else begin
      if (m_v && if_ready) m_v = 0;
      if (m_boot != 0) m_boot--;
      else if (m_fault) m_fault = 1;
      else if (m_issue) begin
        if (mis) begin m_fault = 1; m_faddr = pc_reg; m_issue = 0; end
        else if (imem_gnt) begin m_issue = 0; m_pend = 1; end
      end else if (m_pend) begin
        if (imem_rvalid) begin
          m_pend = 0;
          if (m_drop) m_drop = 0;
          else if (imem_err) begin m_fault = 1; m_faddr = pc_reg; end
          else begin m_v = 1; m_instr = imem_rdata; m_ipc = pc_reg; end
        end
      end else if (can_go) m_issue = 1;
    end
  endtask

  // one clock: drive memory, check comb outputs, clock, check registers
  task automatic step();
    model_comb();
    imem_gnt    = !rst && e_req && ($urandom_range(99) < gnt_pct);
    imem_rvalid = !rst && m_pend && ($urandom_range(99) < rv_pct);
    imem_rdata  = fixed_en ? fixed_data : $urandom();
    imem_err    = force_err || ($urandom_range(99) < err_pct);
    model_comb();
    #1;
    seen_req    = imem_req;
    seen_addr   = imem_addr;
    seen_pcwr   = pc_wr;
    seen_pcnext = pc_next;
    if (!rst) begin
      chk("imem_req", {31'h0, imem_req}, {31'h0, e_req});
      chk("imem_addr", imem_addr, e_addr);
      chk("pc_wr", {31'h0, pc_wr}, {31'h0, e_pcwr});
      chk("pc_next", pc_next, e_pcnext);
    end
    @(posedge CLK);
    model_seq();
    @(negedge CLK);
    pc_reg = pc_nxt;
    chk("if_valid", {31'h0, if_valid}, {31'h0, m_v});
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_ipc);
    chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
    chk("fault_addr", fault_addr, m_faddr);
  endtask

  task automatic first_req(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!seen_req && n < 20);
    chk(tag, 32'(n - 1), 32'(RW + 1));
  endtask

  initial begin
    rst = 1; pc_reg = 32'h0040_0000;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; imem_err = 0;
    redirect_valid = 0; redirect_pc = '0; stall = 0; if_ready = 1;
    gnt_pct = 100; rv_pct = 100; err_pct = 0; force_err = 0;
    fixed_en = 1; fixed_data = 32'h2008_0005;
    model_reset();

    step(); step();
    rst = 0;
    first_req("first_req_latency");
    chk("fetch0_addr", seen_addr, 32'h0040_0000);
    step();
    chk("fetch0_pcwr", {31'h0, seen_pcwr}, 32'h1);
    chk("fetch0_next", seen_pcnext, 32'h0040_0004);
    chk("fetch0_instr", if_instr, 32'h2008_0005);
    chk("fetch0_pc", if_pc, 32'h0040_0000);

    if_ready = 0;
    repeat (5) begin
      step();
      chk("bp_noreq", {31'h0, seen_req}, 32'h0);
      chk("bp_valid", {31'h0, if_valid}, 32'h1);
      chk("bp_instr", if_instr, 32'h2008_0005);
    end
    if_ready = 1;
    step();
    chk("bp_rise_noreq", {31'h0, seen_req}, 32'h0);
    step();
    chk("bp_req", {31'h0, seen_req}, 32'h1);
    chk("fetch1_addr", seen_addr, 32'h0040_0004);

    rv_pct = 0; redirect_valid = 1; redirect_pc = 32'h0040_0100;
    step();
    chk("rd_pcwr", {31'h0, seen_pcwr}, 32'h1);
    chk("rd_next", seen_pcnext, 32'h0040_0100);
    redirect_valid = 0; rv_pct = 100; fixed_data = 32'hDEAD_BEEF;
    step();
    chk("rd_drop_nowr", {31'h0, seen_pcwr}, 32'h0);
    chk("rd_drop_novalid", {31'h0, if_valid}, 32'h0);
    step(); step();
    chk("rd_addr", seen_addr, 32'h0040_0100);
    step();

    redirect_valid = 1; redirect_pc = 32'h0040_0002;
    step();
    redirect_valid = 0;
    step(); step();
    chk("mis_noreq", {31'h0, seen_req}, 32'h0);
    chk("mis_fault", {31'h0, fetch_fault}, 32'h1);
    chk("mis_addr", fault_addr, 32'h0040_0002);
    step();
    chk("mis_sticky", {31'h0, fetch_fault}, 32'h1);
    redirect_valid = 1; redirect_pc = 32'h0040_0008;
    step();
    chk("mis_clr", {31'h0, fetch_fault}, 32'h0);
    chk("mis_clr_addr", fault_addr, 32'h0);
    redirect_valid = 0;

    step(); step();
    force_err = 1;
    step();
    chk("err_nowr", {31'h0, seen_pcwr}, 32'h0);
    chk("err_fault", {31'h0, fetch_fault}, 32'h1);
    chk("err_addr", fault_addr, 32'h0040_0008);
    force_err = 0;
    redirect_valid = 1; redirect_pc = 32'h0040_0010;
    step();
    redirect_valid = 0; stall = 1;
    repeat (3) begin
      step();
      chk("stall_noreq", {31'h0, seen_req}, 32'h0);
    end
    stall = 0;
    step();
    chk("stall_drop_noreq", {31'h0, seen_req}, 32'h0);
    step();
    chk("stall_req", {31'h0, seen_req}, 32'h1);
    chk("stall_addr", seen_addr, 32'h0040_0010);
    step();

    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0;
    step(); step();
    chk("wrap_addr", seen_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_next", seen_pcnext, 32'h0);
    step(); step();
    chk("wrap_addr0", seen_addr, 32'h0);

    rst = 1;
    step();
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
    chk("rst_faddr", fault_addr, 32'h0);
    rst = 0;
    first_req("rst_first_req");
    chk("rst_req_addr", seen_addr, 32'h0040_0000);

    fixed_en = 0; gnt_pct = 70; rv_pct = 60; err_pct = 8;
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(299) == 0);
      stall          = ($urandom_range(99) < 25);
      if_ready       = ($urandom_range(99) < 70);
      redirect_valid = !rst && ($urandom_range(99) < 6);
      redirect_pc    = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(9) == 0) redirect_pc = redirect_pc | 32'($urandom_range(3));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
